reg_dump: RTL and testbench

- Sequential read-out engine for the 16 x 32 register file.
- On a start pulse it walks read addresses 0..2**addr_width-1 through one asynchronous read port of the register file.
- Each word is captured into an output register and streamed out on a valid/ready handshake, tagged with its address.
- Used for debug readback and for context dump to a downstream consumer (UART/bus bridge).

---
 rtl/reg_dump.sv | 119 +++++++++++
 tb/tb_reg_dump.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - sequential register file read-out engine streaming tagged words
// Optional checksum beat: define REG_DUMP_CHECKSUM_EN.
module reg_dump #(
  parameter int data_width = 32,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] rd_addr,
  input  logic [data_width-1:0] rd_data,
  output logic [data_width-1:0] out_data,
  output logic [addr_width-1:0] out_addr,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [addr_width-1:0] max_addr = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
`ifdef REG_DUMP_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t                state;
  logic [addr_width-1:0] counter;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [data_width-1:0] csum;
`endif

  assign rd_addr = counter;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            counter <= '0;
            busy    <= 1'b1;
            state   <= FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        FETCH: begin
          out_data  <= rd_data;
          out_addr  <= counter;
          out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          csum      <= csum ^ rd_data;
`else
          out_last  <= (counter == max_addr);
`endif
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (counter == max_addr) begin
`ifdef REG_DUMP_CHECKSUM_EN
              // Checksum beat is presented straight away; csum already holds the final word.
              out_data  <= csum;
              out_addr  <= '0;
              out_last  <= 1'b1;
              out_valid <= 1'b1;
              state     <= CSUM;
`else
              done      <= 1'b1;
              state     <= DONE;
`endif
            end else begin
              counter <= counter + 1'b1;
              state   <= FETCH;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// tb/tb_reg_dump.sv - directed self-checking bench for reg_dump
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] out_data;
  logic [3:0]  out_addr;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  logic [31:0] regs [16];
  assign rd_data = regs[rd_addr];

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_data [17];
  logic [3:0]  exp_addr [17];
  logic        exp_last [17];
  int          nexp;
  int          exp_cycles;

  logic [31:0] got_data [20];
  logic [3:0]  got_addr [20];
  logic        got_last [20];

  reg_dump #(.data_width(32), .addr_width(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload_ramp();
    for (int i = 0; i < 16; i++) regs[i] = 32'hA000_0000 + i;
  endtask

  task automatic expect_ramp(input bit rewrite3);
    nexp = 16;
    for (int i = 0; i < 16; i++) begin
      exp_data[i] = 32'hA000_0000 + i;
      exp_addr[i] = i[3:0];
      exp_last[i] = (i == 15);
    end
    if (rewrite3) exp_data[3] = 32'hDEAD_BEEF;
    exp_cycles = 32;
`ifdef REG_DUMP_CHECKSUM_EN
    nexp = 17;
    exp_last[15] = 1'b0;
    exp_data[16] = 32'h0;
    for (int i = 0; i < 16; i++) exp_data[16] = exp_data[16] ^ exp_data[i];
    exp_addr[16] = 4'd0;
    exp_last[16] = 1'b1;
    exp_cycles = 33;
`endif
  endtask

  task automatic run_dump(input string tn, input bit toggle, input bit restart5, input bit rewrite1);
    int nb = 0;
    int cyc = 0;
    int done_at = -1;
    int extra = 0;
    logic prev_stall = 1'b0;
    logic [31:0] sd = '0;
    logic [3:0] sa = '0;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tn, "_busy_after_start"}, busy, 1);
    while (done_at < 0 && cyc < 400) begin
      out_ready = toggle ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      start = restart5 && out_valid && (out_addr == 4'd5);
      if (rewrite1 && out_valid && out_addr == 4'd1) regs[3] = 32'hDEAD_BEEF;
      if (prev_stall) begin
        check({tn, "_stall_valid"}, out_valid, 1);
        check({tn, "_stall_data"}, out_data, sd);
        check({tn, "_stall_addr"}, out_addr, sa);
      end
      if (out_valid && out_ready) begin
        if (nb < 20) begin
          got_data[nb] = out_data;
          got_addr[nb] = out_addr;
          got_last[nb] = out_last;
        end
        nb++;
      end
      prev_stall = out_valid && !out_ready;
      sd = out_data;
      sa = out_addr;
      step();
      cyc++;
      if (done) done_at = cyc;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({tn, "_done_seen"}, done_at >= 0, 1);
    if (!toggle && !restart5) check({tn, "_start_to_done"}, done_at, exp_cycles);
    step();
    check({tn, "_done_width"}, done, 0);
    check({tn, "_busy_cleared"}, busy, 0);
    for (int k = 0; k < 8; k++) begin
      if (done || out_valid) extra++;
      step();
    end
    check({tn, "_no_activity_after"}, extra, 0);
    check({tn, "_beat_count"}, nb, nexp);
    for (int i = 0; i < nexp && i < nb && i < 20; i++) begin
      check($sformatf("%s_data%0d", tn, i), got_data[i], exp_data[i]);
      check($sformatf("%s_addr%0d", tn, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_last%0d", tn, i), got_last[i], exp_last[i]);
    end
  endtask

  initial begin
    int waited;
    int extra;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", out_addr, 0);
    check("rst_rd_addr", rd_addr, 0);

    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    step();
    check("rst_start_busy", busy, 0);
    check("rst_start_valid", out_valid, 0);

    preload_ramp();
    expect_ramp(1'b0);
    run_dump("full", 1'b0, 1'b0, 1'b0);

    preload_ramp();
    expect_ramp(1'b0);
    run_dump("stall", 1'b1, 1'b0, 1'b0);

    preload_ramp();
    expect_ramp(1'b0);
    run_dump("restart", 1'b0, 1'b1, 1'b0);

    preload_ramp();
    expect_ramp(1'b1);
    run_dump("rewrite", 1'b0, 1'b0, 1'b1);

    preload_ramp();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    waited = 0;
    while (!(out_valid && out_addr == 4'd7) && waited < 100) begin
      step();
      waited++;
    end
    check("abort_reached_addr7", out_valid && out_addr == 4'd7, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_addr", out_addr, 0);
    check("abort_data", out_data, 0);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || out_valid || busy) extra++;
      step();
    end
    check("abort_quiet", extra, 0);
    expect_ramp(1'b0);
    run_dump("after_abort", 1'b0, 1'b0, 1'b0);

`ifdef REG_DUMP_CHECKSUM_EN
    for (int i = 0; i < 16; i++) regs[i] = i;
    nexp = 17;
    exp_cycles = 33;
    for (int i = 0; i < 16; i++) begin
      exp_data[i] = i;
      exp_addr[i] = i[3:0];
      exp_last[i] = 1'b0;
    end
    exp_data[16] = 32'h0;
    exp_addr[16] = 4'd0;
    exp_last[16] = 1'b1;
    run_dump("csum_idx", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      regs[i] = '0;
      exp_data[i] = '0;
    end
    regs[0] = 32'hFF;
    exp_data[0] = 32'hFF;
    exp_data[16] = 32'hFF;
    run_dump("csum_ff", 1'b1, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
